// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C responder and the benches that drive it.
//   i2c_resp_state_t     : responder protocol state
//   I2C_ACK / I2C_NACK   : SDA level of the 9th (acknowledge) bit
//   I2C_RW_WRITE/READ    : R/W bit of the device-address byte
//   I2C_DEFAULT_DEV_ADDR : default 7-bit device address (HDMI config target)
// ---------------------------------------------------------------------------
package i2c_pkg;

    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;
    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    localparam logic [6:0] I2C_DEFAULT_DEV_ADDR = 7'h39;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_DEV_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK,
        ST_SKIP
    } i2c_resp_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
// Brings the asynchronous SCL/SDA bus levels into the clk domain and decodes
// bus events from the synchronized values.
//   clk, rst   : system clock, synchronous active-low reset
//   scl_in     : raw SCL level
//   sda_in     : raw SDA level
//   sda        : synchronized SDA level
//   scl_rise   : one-clk pulse on an SCL rising edge
//   scl_fall   : one-clk pulse on an SCL falling edge
//   start_det  : one-clk pulse, SDA fell while SCL high
//   stop_det   : one-clk pulse, SDA rose while SCL high
// Parameter SYNC_STAGES (>= 2) sets the synchronizer depth.
// ---------------------------------------------------------------------------
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_hist_reg;
    logic                   sda_hist_reg;
    logic                   scl_s;
    logic                   sda_s;

    // Reset to the idle-bus level so leaving reset never fakes an edge
    // on a quiet bus.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_hist_reg <= 1'b1;
            sda_hist_reg <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_in};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
            scl_hist_reg <= scl_s;
            sda_hist_reg <= sda_s;
        end
    end

    assign scl_s = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s = sda_sync_reg[SYNC_STAGES-1];

    assign sda       = sda_s;
    assign scl_rise  = scl_s & ~scl_hist_reg;
    assign scl_fall  = ~scl_s & scl_hist_reg;
    // SCL must be high both before and after the SDA edge.
    assign start_det = scl_s & scl_hist_reg & sda_hist_reg & ~sda_s;
    assign stop_det  = scl_s & scl_hist_reg & ~sda_hist_reg & sda_s;

endmodule

// File: rtl/i2c_responder.sv
// ---------------------------------------------------------------------------
// i2c_responder
// I2C target: device address, register pointer, then data bytes. Writes are
// presented as a one-clk wr_en strobe; reads (optional) as a one-clk rd_req
// with rd_data expected the clk after the request. The pointer
// auto-increments (mod 256) after every data byte.
//   clk, rst          : system clock (>= 16x SCL), synchronous active-low reset
//   scl_in, sda_in    : bus levels
//   sda_oe            : 1 = pull SDA low
//   wr_en/addr/data   : register write strobe
//   rd_req/addr       : register read request
//   rd_data           : read value
//   busy              : transaction in progress (START seen, no STOP yet)
// Build option: define I2C_RESP_READ_EN to support read transactions;
// otherwise a read address is NACKed and the read path is not built.
// ---------------------------------------------------------------------------
module i2c_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = I2C_DEFAULT_DEV_ADDR,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_req,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda       (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_resp_state_t state_reg;
    logic [3:0]      bit_cnt_reg;
    logic [7:0]      shift_reg;
    logic [7:0]      ptr_reg;
    logic            sda_oe_reg;
    logic            wr_en_reg;
    logic [7:0]      wr_addr_reg;
    logic [7:0]      wr_data_reg;
`ifdef I2C_RESP_READ_EN
    logic            rw_reg;
    logic            rd_req_reg;
    logic [7:0]      rd_addr_reg;
`endif

    logic addr_match;
    assign addr_match = (shift_reg[7:1] == DEV_ADDR);

    // Bit counter convention: counts received/sent bits on scl_rise; the
    // value 8 means the byte is complete and the next scl_fall starts the
    // acknowledge slot. In RACK the value 9 marks "master ACKed".
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= 4'd0;
            shift_reg   <= 8'h00;
            ptr_reg     <= 8'h00;
            sda_oe_reg  <= 1'b0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= 8'h00;
            wr_data_reg <= 8'h00;
`ifdef I2C_RESP_READ_EN
            rw_reg      <= I2C_RW_WRITE;
            rd_req_reg  <= 1'b0;
            rd_addr_reg <= 8'h00;
`endif
        end else begin
            wr_en_reg <= 1'b0;
`ifdef I2C_RESP_READ_EN
            rd_req_reg <= 1'b0;
`endif
            if (stop_det) begin
                state_reg   <= ST_IDLE;
                bit_cnt_reg <= 4'd0;
                sda_oe_reg  <= 1'b0;
            end else if (start_det) begin
                // Also covers repeated START: partial byte dropped, pointer kept.
                state_reg   <= ST_DEV;
                bit_cnt_reg <= 4'd0;
                sda_oe_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_DEV: begin
                        if (scl_rise && bit_cnt_reg < 4'd8) begin
                            shift_reg   <= {shift_reg[6:0], sda_s};
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                            if (addr_match && shift_reg[0] == I2C_RW_WRITE) begin
`ifdef I2C_RESP_READ_EN
                                rw_reg     <= I2C_RW_WRITE;
`endif
                                state_reg  <= ST_DEV_ACK;
                                sda_oe_reg <= 1'b1;
`ifdef I2C_RESP_READ_EN
                            end else if (addr_match) begin
                                rw_reg     <= I2C_RW_READ;
                                state_reg  <= ST_DEV_ACK;
                                sda_oe_reg <= 1'b1;
`endif
                            end else begin
                                state_reg <= ST_SKIP;
                            end
                        end
                    end

                    ST_DEV_ACK: begin
                        if (scl_fall) begin
                            sda_oe_reg  <= 1'b0;
                            bit_cnt_reg <= 4'd0;
`ifdef I2C_RESP_READ_EN
                            if (rw_reg == I2C_RW_READ) begin
                                state_reg   <= ST_RDATA;
                                rd_req_reg  <= 1'b1;
                                rd_addr_reg <= ptr_reg;
                            end else begin
                                state_reg <= ST_PTR;
                            end
`else
                            state_reg <= ST_PTR;
`endif
                        end
                    end

                    ST_PTR: begin
                        if (scl_rise && bit_cnt_reg < 4'd8) begin
                            shift_reg   <= {shift_reg[6:0], sda_s};
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                            ptr_reg    <= shift_reg;
                            sda_oe_reg <= 1'b1;
                            state_reg  <= ST_PTR_ACK;
                        end
                    end

                    ST_WDATA: begin
                        if (scl_rise && bit_cnt_reg < 4'd8) begin
                            shift_reg   <= {shift_reg[6:0], sda_s};
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                            wr_en_reg   <= 1'b1;
                            wr_addr_reg <= ptr_reg;
                            wr_data_reg <= shift_reg;
                            ptr_reg     <= ptr_reg + 8'd1;
                            sda_oe_reg  <= 1'b1;
                            state_reg   <= ST_WDATA_ACK;
                        end
                    end

                    ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe_reg  <= 1'b0;
                            bit_cnt_reg <= 4'd0;
                            state_reg   <= ST_WDATA;
                        end
                    end

`ifdef I2C_RESP_READ_EN
                    ST_RDATA: begin
                        if (rd_req_reg) begin
                            // Read value arrives the clk after the request;
                            // SCL is still low, so the MSB goes out now.
                            shift_reg   <= rd_data;
                            sda_oe_reg  <= ~rd_data[7];
                            bit_cnt_reg <= 4'd0;
                        end else if (scl_rise && bit_cnt_reg < 4'd8) begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_reg == 4'd8) begin
                                sda_oe_reg <= 1'b0;
                                state_reg  <= ST_RACK;
                            end else begin
                                shift_reg  <= {shift_reg[6:0], 1'b0};
                                sda_oe_reg <= ~shift_reg[6];
                            end
                        end
                    end

                    ST_RACK: begin
                        if (scl_rise && bit_cnt_reg == 4'd8) begin
                            if (sda_s == I2C_NACK) begin
                                state_reg <= ST_SKIP;
                            end else begin
                                ptr_reg     <= ptr_reg + 8'd1;
                                bit_cnt_reg <= 4'd9;
                            end
                        end else if (scl_fall && bit_cnt_reg == 4'd9) begin
                            // Next byte is requested once SCL is low so SDA
                            // never moves while SCL is high.
                            state_reg   <= ST_RDATA;
                            rd_req_reg  <= 1'b1;
                            rd_addr_reg <= ptr_reg;
                            bit_cnt_reg <= 4'd0;
                        end
                    end
`endif

                    ST_SKIP: begin
                        sda_oe_reg <= 1'b0;
                    end

                    ST_IDLE: begin
                        sda_oe_reg <= 1'b0;
                    end

                    default: begin
                        state_reg  <= ST_IDLE;
                        sda_oe_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe  = sda_oe_reg;
    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;
    assign busy    = (state_reg != ST_IDLE);

`ifdef I2C_RESP_READ_EN
    assign rd_req  = rd_req_reg;
    assign rd_addr = rd_addr_reg;
`else
    logic unused_rd_data;
    assign unused_rd_data = ^rd_data;
    assign rd_req  = 1'b0;
    assign rd_addr = 8'h00;
`endif

endmodule

// File: tb/tb_i2c_responder.sv
// ---------------------------------------------------------------------------
// tb_i2c_responder
// Directed bench for i2c_responder: a bit-banged bus master drives SCL/SDA
// (SDA is wired-AND with the responder's sda_oe); write/read strobes are
// logged on the falling clk edge and compared with hand-computed values.
// Read checks are built when I2C_RESP_READ_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_responder;

    localparam int Q = 5;   // clks per quarter of the SCL bit slot

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];

    always #5 clk = ~clk;

    assign scl_in  = scl_m;
    assign sda_in  = sda_m & ~sda_oe;
    assign rd_data = rd_addr ^ 8'h5A;

    i2c_responder #(
        .DEV_ADDR    (7'h39),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .scl_in  (scl_in),
        .sda_in  (sda_in),
        .sda_oe  (sda_oe),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    // One log entry per clk the strobe is high, so a stretched pulse shows up.
    always @(negedge clk) begin
        if (wr_en)  wr_q.push_back({wr_addr, wr_data});
        if (rd_req) rd_q.push_back(rd_addr);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %-16s observed %h expected %h ok", tag, obs, exp);
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] wr_at(input int i);
        if (i < wr_q.size()) return wr_q[i];
        return 16'hxxxx;
    endfunction

    function automatic logic [15:0] rd_at(input int i);
        if (i < rd_q.size()) return {8'h00, rd_q[i]};
        return 16'hxxxx;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL pulse: master drives 'drive' (1 = released), samples the line.
    task automatic clock_bit(input logic drive, output logic sampled);
        sda_m = drive;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sampled = sda_in;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    // START or repeated START, ending with SCL low.
    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, ack);
        $display("tx byte %h ack %b", b, ack);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            b[i] = s;
        end
        clock_bit(master_ack, s);
        $display("rx byte %h master ack %b", b, master_ack);
    endtask

    logic       ack;
    logic [7:0] rb;
    logic       s;

    initial begin
        rst   = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(4);
        check("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
        check("rst_busy",   {15'd0, busy},   16'd0);
        check("rst_wr_en",  {15'd0, wr_en},  16'd0);
        check("rst_rd_req", {15'd0, rd_req}, 16'd0);
        rst = 1'b1;
        wait_clk(4);

        // Single write: 0x72 0x41 0x10
        i2c_start();
        send_byte(8'h72, ack); check("wr_dev_ack",  {15'd0, ack}, 16'd0);
        send_byte(8'h41, ack); check("wr_ptr_ack",  {15'd0, ack}, 16'd0);
        send_byte(8'h10, ack); check("wr_data_ack", {15'd0, ack}, 16'd0);
        check("wr_busy_mid", {15'd0, busy}, 16'd1);
        i2c_stop();
        check("wr_busy_end", {15'd0, busy}, 16'd0);
        check("wr_count", wr_q.size(), 16'd1);
        check("wr_0", wr_at(0), 16'h4110);
        wr_q.delete();

        // Wrong address: 0x74
        i2c_start();
        send_byte(8'h74, ack); check("bad_dev_nack", {15'd0, ack}, 16'd1);
        send_byte(8'h41, ack); check("bad_ptr_nack", {15'd0, ack}, 16'd1);
        send_byte(8'h10, ack);
        check("bad_busy_skip", {15'd0, busy}, 16'd1);
        i2c_stop();
        check("bad_busy_end", {15'd0, busy}, 16'd0);
        check("bad_wr_count", wr_q.size(), 16'd0);
        wr_q.delete();

        // Burst with pointer wrap
        i2c_start();
        send_byte(8'h72, ack);
        send_byte(8'hFE, ack);
        send_byte(8'hAA, ack); check("burst_ack0", {15'd0, ack}, 16'd0);
        send_byte(8'hBB, ack); check("burst_ack1", {15'd0, ack}, 16'd0);
        send_byte(8'hCC, ack); check("burst_ack2", {15'd0, ack}, 16'd0);
        i2c_stop();
        check("burst_count", wr_q.size(), 16'd3);
        check("burst_0", wr_at(0), 16'hFEAA);
        check("burst_1", wr_at(1), 16'hFFBB);
        check("burst_2", wr_at(2), 16'h00CC);
        wr_q.delete();

        // Pointer write, repeated START, read
        i2c_start();
        send_byte(8'h72, ack);
        send_byte(8'h10, ack);
        i2c_start();
        send_byte(8'h73, ack);
`ifdef I2C_RESP_READ_EN
        check("rd_dev_ack", {15'd0, ack}, 16'd0);
        read_byte(1'b0, rb); check("rd_byte0", {8'h00, rb}, 16'h004A);
        read_byte(1'b1, rb); check("rd_byte1", {8'h00, rb}, 16'h004B);
        check("rd_busy_skip", {15'd0, busy}, 16'd1);
        check("rd_sda_rel",   {15'd0, sda_oe}, 16'd0);
        i2c_stop();
        check("rd_req_count", rd_q.size(), 16'd2);
        check("rd_req_0", rd_at(0), 16'h0010);
        check("rd_req_1", rd_at(1), 16'h0011);
`else
        check("rd_dev_nack", {15'd0, ack}, 16'd1);
        i2c_stop();
        check("rd_req_none", rd_q.size(), 16'd0);
`endif
        check("rd_wr_count", wr_q.size(), 16'd0);
        rd_q.delete();
        wr_q.delete();

        // STOP after 4 data bits, then a normal transaction
        i2c_start();
        send_byte(8'h72, ack);
        send_byte(8'h41, ack);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        clock_bit(1'b1, s);
        clock_bit(1'b1, s);
        i2c_stop();
        check("abort_wr_count", wr_q.size(), 16'd0);
        check("abort_busy",     {15'd0, busy}, 16'd0);
        check("abort_sda_oe",   {15'd0, sda_oe}, 16'd0);
        i2c_start();
        send_byte(8'h72, ack); check("after_dev_ack", {15'd0, ack}, 16'd0);
        send_byte(8'h05, ack);
        send_byte(8'h99, ack);
        i2c_stop();
        check("after_count", wr_q.size(), 16'd1);
        check("after_wr",    wr_at(0), 16'h0599);
        wr_q.delete();

        // Reset while the responder is holding the DEV_ACK low
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] dev;
            dev = 8'h72;
            clock_bit(dev[i], s);
        end
        check("ack_driving", {15'd0, sda_oe}, 16'd1);
        rst = 1'b0;
        wait_clk(1);
        check("rst_mid_sda_oe", {15'd0, sda_oe}, 16'd0);
        check("rst_mid_busy",   {15'd0, busy},   16'd0);
        rst = 1'b1;
        wait_clk(2);
        i2c_stop();
`ifdef I2C_RESP_READ_EN
        // Pointer must be back to 0x00: read without setting it
        i2c_start();
        send_byte(8'h73, ack);
        read_byte(1'b1, rb); check("rst_ptr_byte", {8'h00, rb}, 16'h005A);
        i2c_stop();
        check("rst_ptr_req", rd_at(0), 16'h0000);
        rd_q.delete();
`endif
        i2c_start();
        send_byte(8'h72, ack); check("post_rst_ack", {15'd0, ack}, 16'd0);
        send_byte(8'h20, ack);
        send_byte(8'h33, ack);
        i2c_stop();
        check("post_rst_wr", wr_at(0), 16'h2033);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #20ms;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
